axi_rw_bridge: RTL and testbench
================================

# axi_rw_bridge

Parametrised single-outstanding AXI4 master bridge serving the instruction-fetch and LSU ports of the core. Extends the read-only path with a full write path (AW/W/B), configurable data/address/ID widths, fixed-priority arbitration, registered AXI outputs and response-error reporting. Sits between IFU/LSU and the SoC AXI crossbar.

## Interface
Parameters:
- DW, 32, data width (32 or 64; DW/8 strobe bits)
- AW, 32, address width
- IDW, 4, AXI ID width

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- arid/araddr/arlen/arsize/arburst  out  IDW/AW/8/3/2  read address
- arlock/arcache/arprot, awlock/awcache/awprot  out  1/4/3 each  constant 0
- arvalid out 1, arready in 1  AR handshake
- rid/rdata/rresp/rlast/rvalid  in  IDW/DW/2/1/1  read data
- rready  out  1  read data accept
- awid/awaddr/awlen/awsize/awburst  out  IDW/AW/8/3/2  write address
- awvalid out 1, awready in 1  AW handshake
- wdata/wstrb/wlast/wvalid  out  DW/DW/8/1/1  write data
- wready  in  1  W accept
- bid/bresp/bvalid  in  IDW/2/1  write response
- bready  out  1  B accept
- inst_req  in  1  fetch request
- inst_addr  in  AW  fetch address
- inst_addr_ok  out  1  fetch accepted (comb)
- inst_data_ok  out  1  fetch data valid, 1-cycle pulse
- inst_rdata  out  DW  fetch data
- inst_err  out  1  rresp != OKAY, with inst_data_ok
- data_req  in  1  LSU request
- data_wr  in  1  1 = write
- data_wstrb  in  DW/8  byte enables
- data_addr  in  AW  LSU address
- data_wdata  in  DW  store data
- data_addr_ok  out  1  LSU accepted (comb)
- data_data_ok  out  1  load data / store done, 1-cycle pulse
- data_rdata  out  DW  load data (0 on writes)
- data_err  out  1  rresp/bresp != OKAY, with data_data_ok

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE: grant data_req over inst_req. data_addr_ok = data_req; inst_addr_ok = inst_req & ~data_req. Both 0 outside IDLE.
- On grant latch addr, wdata, wstrb, wr, source (0 inst, 1 data). Read -> RD_ADDR; write -> WR_REQ.
- arid/awid = source zero-extended to IDW. arlen/awlen = 0, arsize/awsize = log2(DW/8), arburst/awburst = 2'b01, wlast = 1.
- RD_ADDR: arvalid = 1; on arready -> RD_DATA.
- RD_DATA: rready = 1; on rvalid: pulse source's data_ok, drive rdata on that source's rdata, err = (rresp != 0); -> IDLE. rid not checked.
- WR_REQ: awvalid and wvalid rise together; each drops independently after its handshake (aw_done/w_done flags); -> WR_RESP in cycle both done (including same cycle).
- WR_RESP: bready = 1; on bvalid: pulse data_data_ok, data_err = (bresp != 0), data_rdata = 0; -> IDLE.
- inst_rdata/data_rdata hold last value between pulses; only meaningful with data_ok.
- Requests from a client while not granted are ignored; client must hold req until addr_ok.
- Reset (any state): state IDLE, all valid/ready/ok/err outputs 0, addr/data regs 0; in-flight transaction abandoned, no completion pulse.

## Timing
- Grant cycle T (req & addr_ok). arvalid/awvalid/wvalid high from T+1 (registered).
- Read min latency: arready at T+1, rvalid at T+2 -> data_ok at T+2.
- Write min latency: awready & wready at T+1, bvalid at T+2 -> data_data_ok at T+2.
- data_ok is combinational from rvalid/bvalid in the completion state.
- Next grant earliest one cycle after completion (back in IDLE); back-to-back throughput one transaction per 3 cycles minimum.
- AXI rule: once asserted, arvalid/awvalid/wvalid held with stable payload until handshake.

## Test plan
- Single fetch: inst_req, addr 0x1C000000, arready at T+1, rvalid rdata 0x02800000 at T+3 -> arid 0, araddr 0x1C000000, inst_data_ok at T+3, inst_rdata 0x02800000, inst_err 0.
- Simultaneous inst_req and data_req (load 0x100) -> data_addr_ok 1, inst_addr_ok 0; araddr 0x100 arid 1; fetch granted in the IDLE cycle after data_data_ok.
- Store 0xDEADBEEF strb 4'b0011 addr 0x200; wready T+1, awready T+3, bvalid T+4 -> wvalid drops after T+1, awvalid held to T+3, wstrb 0x3, data_data_ok at T+4.
- Load with rresp 2'b10 -> data_data_ok and data_err 1 same cycle; store with bresp 2'b11 -> data_err 1.
- arready held low 10 cycles -> arvalid/araddr stable all 10 cycles, no addr_ok.
- aresetn low during RD_DATA -> all valids 0 immediately; after release, no stale data_ok, new request accepted from IDLE.

Source files
------------

// File: rtl/axi_rw_bridge.sv
// Single-outstanding AXI4 master bridge for the instruction-fetch and LSU ports.
// The LSU has priority over fetch; read (AR/R) and write (AW/W/B) paths use single-beat bursts.
module axi_rw_bridge #(
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int IDW = 4
) (
   input  logic              aclk,
   input  logic              aresetn,
   // AR channel
   output logic [IDW-1:0]    arid,
   output logic [AW-1:0]     araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic              arlock,
   output logic [3:0]        arcache,
   output logic [2:0]        arprot,
   output logic              arvalid,
   input  logic              arready,
   // R channel
   input  logic [IDW-1:0]    rid,
   input  logic [DW-1:0]     rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic              rvalid,
   output logic              rready,
   // AW channel
   output logic [IDW-1:0]    awid,
   output logic [AW-1:0]     awaddr,
   output logic [7:0]        awlen,
   output logic [2:0]        awsize,
   output logic [1:0]        awburst,
   output logic              awlock,
   output logic [3:0]        awcache,
   output logic [2:0]        awprot,
   output logic              awvalid,
   input  logic              awready,
   // W channel
   output logic [DW-1:0]     wdata,
   output logic [DW/8-1:0]   wstrb,
   output logic              wlast,
   output logic              wvalid,
   input  logic              wready,
   // B channel
   input  logic [IDW-1:0]    bid,
   input  logic [1:0]        bresp,
   input  logic              bvalid,
   output logic              bready,
   // Instruction-fetch port
   input  logic              inst_req,
   input  logic [AW-1:0]     inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DW-1:0]     inst_rdata,
   output logic              inst_err,
   // LSU port
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [DW/8-1:0]   data_wstrb,
   input  logic [AW-1:0]     data_addr,
   input  logic [DW-1:0]     data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DW-1:0]     data_rdata,
   output logic              data_err
);

   localparam int          SW   = DW / 8;
   localparam logic [2:0]  SIZE = 3'($clog2(SW));

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   wstrb_q, wstrb_d;
   logic            src_q, src_d;
   logic            aw_done_q, aw_done_d;
   logic            w_done_q, w_done_d;
   logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
   logic [DW-1:0]   data_rdata_q, data_rdata_d;

   // Response IDs and rlast are not checked: only one transaction is ever in flight.
   logic unused_resp_fields;
   assign unused_resp_fields = ^{rid, bid, rlast};

   assign arid    = IDW'(src_q);
   assign araddr  = addr_q;
   assign arlen   = 8'd0;
   assign arsize  = SIZE;
   assign arburst = 2'b01;
   assign arlock  = 1'b0;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;

   assign awid    = IDW'(src_q);
   assign awaddr  = addr_q;
   assign awlen   = 8'd0;
   assign awsize  = SIZE;
   assign awburst = 2'b01;
   assign awlock  = 1'b0;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;

   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      src_d        = src_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;

      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_data_ok = 1'b0;
      inst_err     = 1'b0;
      data_err     = 1'b0;
      inst_rdata   = inst_rdata_q;
      data_rdata   = data_rdata_q;
      arvalid      = 1'b0;
      rready       = 1'b0;
      awvalid      = 1'b0;
      wvalid       = 1'b0;
      bready       = 1'b0;

      unique case (state_q)
         IDLE: begin
            data_addr_ok = data_req;
            inst_addr_ok = inst_req & ~data_req;
            if (data_req) begin
               addr_d    = data_addr;
               wdata_d   = data_wdata;
               wstrb_d   = data_wstrb;
               src_d     = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = data_wr ? WR_REQ : RD_ADDR;
            end else if (inst_req) begin
               addr_d  = inst_addr;
               wdata_d = '0;
               wstrb_d = '0;
               src_d   = 1'b0;
               state_d = RD_ADDR;
            end
         end
         RD_ADDR: begin
            arvalid = 1'b1;
            if (arready) state_d = RD_DATA;
         end
         RD_DATA: begin
            rready = 1'b1;
            if (rvalid) begin
               if (src_q) begin
                  data_data_ok = 1'b1;
                  data_err     = (rresp != 2'b00);
                  data_rdata   = rdata;
                  data_rdata_d = rdata;
               end else begin
                  inst_data_ok = 1'b1;
                  inst_err     = (rresp != 2'b00);
                  inst_rdata   = rdata;
                  inst_rdata_d = rdata;
               end
               state_d = IDLE;
            end
         end
         WR_REQ: begin
            // AW and W complete independently; leave once both have handshaken.
            awvalid   = ~aw_done_q;
            wvalid    = ~w_done_q;
            aw_done_d = aw_done_q | (awvalid & awready);
            w_done_d  = w_done_q | (wvalid & wready);
            if (aw_done_d && w_done_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            bready = 1'b1;
            if (bvalid) begin
               data_data_ok = 1'b1;
               data_err     = (bresp != 2'b00);
               data_rdata   = '0;
               data_rdata_d = '0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         src_q        <= 1'b0;
         aw_done_q    <= 1'b0;
         w_done_q     <= 1'b0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         src_q        <= src_d;
         aw_done_q    <= aw_done_d;
         w_done_q     <= w_done_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

endmodule

// File: tb/tb_axi_rw_bridge.sv
// Directed bench for axi_rw_bridge: expected completions are queued at grant time
// and compared when a data_ok pulse appears.
module tb_axi_rw_bridge;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int IDW = 4;

   logic            aclk, aresetn;
   logic [IDW-1:0]  arid, awid, rid, bid;
   logic [AW-1:0]   araddr, awaddr;
   logic [7:0]      arlen, awlen;
   logic [2:0]      arsize, awsize, arprot, awprot;
   logic [1:0]      arburst, awburst, rresp, bresp;
   logic            arlock, awlock;
   logic [3:0]      arcache, awcache;
   logic            arvalid, arready, rlast, rvalid, rready;
   logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [DW-1:0]   rdata, wdata;
   logic [DW/8-1:0] wstrb, data_wstrb;
   logic            inst_req, inst_addr_ok, inst_data_ok, inst_err;
   logic [AW-1:0]   inst_addr, data_addr;
   logic [DW-1:0]   inst_rdata, data_wdata, data_rdata;
   logic            data_req, data_wr, data_addr_ok, data_data_ok, data_err;

   typedef struct {
      bit          src;
      logic [31:0] data;
      bit          err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   axi_rw_bridge #(.DW(DW), .AW(AW), .IDW(IDW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .inst_err(inst_err),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata), .data_err(data_err)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks follow another unit later.
   task automatic next_cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic pop_check();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_underflow", sb.size(), 1);
      end else begin
         e = sb.pop_front();
         if (!e.src) begin
            chk("inst_data_ok", inst_data_ok, 1);
            chk("inst_rdata", inst_rdata, e.data);
            chk("inst_err", inst_err, e.err);
            chk("data_data_ok_quiet", data_data_ok, 0);
         end else begin
            chk("data_data_ok", data_data_ok, 1);
            chk("data_rdata", data_rdata, e.data);
            chk("data_err", data_err, e.err);
            chk("inst_data_ok_quiet", inst_data_ok, 0);
         end
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_rready"}, rready, 0);
      chk({tag, "_awvalid"}, awvalid, 0);
      chk({tag, "_wvalid"}, wvalid, 0);
      chk({tag, "_bready"}, bready, 0);
      chk({tag, "_inst_data_ok"}, inst_data_ok, 0);
      chk({tag, "_data_data_ok"}, data_data_ok, 0);
      chk({tag, "_inst_err"}, inst_err, 0);
      chk({tag, "_data_err"}, data_err, 0);
   endtask

   initial begin
      aresetn = 1'b0;
      arready = 0; awready = 0; wready = 0;
      rid = '0; bid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 0;
      bresp = 2'b00; bvalid = 0;
      inst_req = 0; inst_addr = '0;
      data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;

      // Reset state
      next_cyc(); next_cyc();
      #1;
      chk_quiet("rst");
      chk("rst_inst_addr_ok", inst_addr_ok, 0);
      chk("rst_data_addr_ok", data_addr_ok, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_inst_rdata", inst_rdata, 0);
      next_cyc();
      aresetn = 1'b1;

      // Single fetch, rvalid at T+3
      next_cyc();
      inst_req = 1; inst_addr = 32'h1C00_0000;
      #1;
      chk("f1_inst_addr_ok", inst_addr_ok, 1);
      chk("f1_data_addr_ok", data_addr_ok, 0);
      sb.push_back('{src: 1'b0, data: 32'h0280_0000, err: 1'b0});
      next_cyc();
      inst_req = 0; inst_addr = '0; arready = 1;
      #1;
      chk("f1_arvalid", arvalid, 1);
      chk("f1_araddr", araddr, 32'h1C00_0000);
      chk("f1_arid", arid, 0);
      chk("f1_arlen", arlen, 0);
      chk("f1_arsize", arsize, 2);
      chk("f1_arburst", arburst, 1);
      chk("f1_inst_addr_ok_busy", inst_addr_ok, 0);
      next_cyc();
      arready = 0;
      #1;
      chk("f1_arvalid_low", arvalid, 0);
      chk("f1_rready", rready, 1);
      chk("f1_no_early_ok", inst_data_ok, 0);
      next_cyc();
      rvalid = 1; rdata = 32'h0280_0000;
      #1;
      pop_check();
      next_cyc();
      rvalid = 0; rdata = 32'hFFFF_FFFF;
      #1;
      chk("f1_hold_rdata", inst_rdata, 32'h0280_0000);
      chk("f1_ok_pulse", inst_data_ok, 0);

      // Simultaneous requests: LSU load wins, fetch follows
      next_cyc();
      inst_req = 1; inst_addr = 32'h1C00_0004;
      data_req = 1; data_wr = 0; data_addr = 32'h100;
      #1;
      chk("arb_data_addr_ok", data_addr_ok, 1);
      chk("arb_inst_addr_ok", inst_addr_ok, 0);
      sb.push_back('{src: 1'b1, data: 32'hAAAA_5555, err: 1'b0});
      next_cyc();
      data_req = 0; arready = 1;
      #1;
      chk("arb_araddr", araddr, 32'h100);
      chk("arb_arid", arid, 1);
      chk("arb_arvalid", arvalid, 1);
      chk("arb_inst_wait", inst_addr_ok, 0);
      next_cyc();
      arready = 0; rvalid = 1; rdata = 32'hAAAA_5555;
      #1;
      pop_check();
      chk("arb_inst_wait2", inst_addr_ok, 0);
      next_cyc();
      rvalid = 0;
      #1;
      chk("arb_fetch_grant", inst_addr_ok, 1);
      sb.push_back('{src: 1'b0, data: 32'h1111_2222, err: 1'b0});
      next_cyc();
      inst_req = 0; arready = 1;
      #1;
      chk("arb_f_araddr", araddr, 32'h1C00_0004);
      chk("arb_f_arid", arid, 0);
      next_cyc();
      arready = 0; rvalid = 1; rdata = 32'h1111_2222;
      #1;
      pop_check();
      next_cyc();
      rvalid = 0;

      // Store: wready T+1, awready T+3, bvalid T+4
      next_cyc();
      data_req = 1; data_wr = 1; data_addr = 32'h200; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0011;
      #1;
      chk("st_addr_ok", data_addr_ok, 1);
      sb.push_back('{src: 1'b1, data: 32'h0, err: 1'b0});
      next_cyc();
      data_req = 0; data_wr = 0; data_wdata = '0; data_wstrb = '0; wready = 1;
      #1;
      chk("st_awvalid_t1", awvalid, 1);
      chk("st_wvalid_t1", wvalid, 1);
      chk("st_awaddr", awaddr, 32'h200);
      chk("st_awid", awid, 1);
      chk("st_wdata", wdata, 32'hDEAD_BEEF);
      chk("st_wstrb", wstrb, 4'h3);
      chk("st_wlast", wlast, 1);
      chk("st_awsize", awsize, 2);
      chk("st_arvalid", arvalid, 0);
      next_cyc();
      wready = 0;
      #1;
      chk("st_wvalid_t2", wvalid, 0);
      chk("st_awvalid_t2", awvalid, 1);
      chk("st_awaddr_t2", awaddr, 32'h200);
      chk("st_bready_t2", bready, 0);
      next_cyc();
      awready = 1;
      #1;
      chk("st_awvalid_t3", awvalid, 1);
      chk("st_wvalid_t3", wvalid, 0);
      next_cyc();
      awready = 0; bvalid = 1; bresp = 2'b00;
      #1;
      chk("st_awvalid_t4", awvalid, 0);
      chk("st_bready_t4", bready, 1);
      pop_check();
      next_cyc();
      bvalid = 0;

      // Load with SLVERR
      next_cyc();
      data_req = 1; data_addr = 32'h300;
      #1;
      chk("le_addr_ok", data_addr_ok, 1);
      sb.push_back('{src: 1'b1, data: 32'h1234_5678, err: 1'b1});
      next_cyc();
      data_req = 0; arready = 1;
      #1;
      chk("le_araddr", araddr, 32'h300);
      next_cyc();
      arready = 0; rvalid = 1; rresp = 2'b10; rdata = 32'h1234_5678;
      #1;
      pop_check();
      next_cyc();
      rvalid = 0; rresp = 2'b00;

      // Store with DECERR, AW and W accepted in the same cycle
      next_cyc();
      data_req = 1; data_wr = 1; data_addr = 32'h400; data_wdata = 32'h0BAD_F00D; data_wstrb = 4'hF;
      #1;
      chk("se_addr_ok", data_addr_ok, 1);
      sb.push_back('{src: 1'b1, data: 32'h0, err: 1'b1});
      next_cyc();
      data_req = 0; data_wr = 0; awready = 1; wready = 1;
      #1;
      chk("se_awvalid", awvalid, 1);
      chk("se_wvalid", wvalid, 1);
      chk("se_wstrb", wstrb, 4'hF);
      next_cyc();
      awready = 0; wready = 0; bvalid = 1; bresp = 2'b11;
      #1;
      chk("se_awvalid_low", awvalid, 0);
      chk("se_wvalid_low", wvalid, 0);
      pop_check();
      next_cyc();
      bvalid = 0; bresp = 2'b00;

      // AR stall for 10 cycles; a competing LSU request is ignored meanwhile
      next_cyc();
      inst_req = 1; inst_addr = 32'h1C00_0100;
      #1;
      chk("stall_grant", inst_addr_ok, 1);
      sb.push_back('{src: 1'b0, data: 32'h5A5A_A5A5, err: 1'b0});
      for (int i = 0; i < 10; i++) begin
         next_cyc();
         inst_req = 0; inst_addr = '0;
         data_req = 1; data_addr = 32'h999;
         #1;
         chk("stall_arvalid", arvalid, 1);
         chk("stall_araddr", araddr, 32'h1C00_0100);
         chk("stall_data_addr_ok", data_addr_ok, 0);
      end
      next_cyc();
      data_req = 0; arready = 1;
      #1;
      chk("stall_arvalid_end", arvalid, 1);
      next_cyc();
      arready = 0; rvalid = 1; rdata = 32'h5A5A_A5A5;
      #1;
      pop_check();
      next_cyc();
      rvalid = 0;

      // Reset asserted while in RD_DATA
      next_cyc();
      data_req = 1; data_wr = 0; data_addr = 32'h500;
      #1;
      chk("rr_addr_ok", data_addr_ok, 1);
      next_cyc();
      data_req = 0; arready = 1;
      next_cyc();
      arready = 0;
      #1;
      chk("rr_rready", rready, 1);
      aresetn = 1'b0;
      rvalid = 1; rdata = 32'hCAFE_CAFE;
      #1;
      chk_quiet("rr_in_rst");
      next_cyc();
      rvalid = 0;
      aresetn = 1'b1;
      #1;
      chk("rr_data_rdata_cleared", data_rdata, 0);
      chk("rr_inst_rdata_cleared", inst_rdata, 0);
      chk("rr_araddr_cleared", araddr, 0);
      next_cyc();
      rvalid = 1; rdata = 32'hCAFE_CAFE;
      #1;
      chk_quiet("rr_stale");
      next_cyc();
      rvalid = 0;
      data_req = 1; data_addr = 32'h600;
      #1;
      chk("rr_new_addr_ok", data_addr_ok, 1);
      sb.push_back('{src: 1'b1, data: 32'h0600_0600, err: 1'b0});
      next_cyc();
      data_req = 0; arready = 1;
      #1;
      chk("rr_new_araddr", araddr, 32'h600);
      next_cyc();
      arready = 0; rvalid = 1; rdata = 32'h0600_0600;
      #1;
      pop_check();
      next_cyc();
      rvalid = 0;
      #1;
      chk("sb_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
